rsa_exp_ctrl: RTL and testbench

RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_exp_ctrl_if.sv | 36 +++
 rtl/rsa_exp_shifter.sv | 60 ++++++
 rtl/rsa_exp_ctrl.sv | 149 ++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation controller.
// Optional feature macro used by this block: RSA_EXP_EARLY_EXIT_EN.
package rsa_pkg;

  localparam int RSA_WIDTH_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    MUL,
    SQR,
    DONE
  } rsa_state_e;

  // Width of the exponent bit index; never narrower than one bit.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/rsa_exp_ctrl_if.sv
// Request, precompute-engine and Montgomery-engine signals of rsa_exp_ctrl.
// slave is the controller's view; master is the environment's view.
interface rsa_exp_ctrl_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] result;
  logic             finish;
  logic             busy;
  logic             prep_start;
  logic [WIDTH-1:0] prep_a;
  logic [WIDTH-1:0] prep_N;
  logic [WIDTH-1:0] prep_m;
  logic             prep_finish;
  logic             mont_start;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic [WIDTH-1:0] mont_N;
  logic [WIDTH-1:0] mont_m;
  logic             mont_finish;

  modport slave (
    input  start, N, y, d, prep_m, prep_finish, mont_m, mont_finish,
    output result, finish, busy, prep_start, prep_a, prep_N,
           mont_start, mont_a, mont_b, mont_N
  );

  modport master (
    output start, N, y, d, prep_m, prep_finish, mont_m, mont_finish,
    input  result, finish, busy, prep_start, prep_a, prep_N,
           mont_start, mont_a, mont_b, mont_N
  );
endinterface

// File: rtl/rsa_exp_shifter.sv
// Captured exponent and bit index for the square-and-multiply walk.
// With RSA_EXP_EARLY_EXIT_EN defined it also locates the highest set bit.
module rsa_exp_shifter import rsa_pkg::*; #(
  parameter int WIDTH = RSA_WIDTH_DEFAULT,
  parameter int IW    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             advance,
  output logic             bit0,
  output logic             next_bit,
  output logic             last
`ifdef RSA_EXP_EARLY_EXIT_EN
  ,
  output logic             at_top,
  output logic             d_zero
`endif
);

  logic [WIDTH-1:0] d_q;
  logic [IW-1:0]    i_q;
  logic [IW-1:0]    i_nxt;

  // Capture the exponent on load; step the index after each completed square.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= '0;
      i_q <= '0;
    end else if (load) begin
      d_q <= d_in;
      i_q <= '0;
    end else if (advance && !last) begin
      i_q <= i_nxt;
    end
  end

  assign i_nxt    = i_q + IW'(1);
  assign last     = (i_q == IW'(WIDTH - 1));
  assign bit0     = d_q[0];
  // Only consulted when not on the last bit, so i_nxt is always in range.
  assign next_bit = d_q[i_nxt];

`ifdef RSA_EXP_EARLY_EXIT_EN
  logic [IW-1:0] top_idx;

  // Highest set bit of the exponent: the last multiply that changes m.
  always_comb begin
    top_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (d_q[k]) top_idx = IW'(k);
    end
  end

  assign at_top = (i_q == top_idx);
  assign d_zero = (d_q == '0);
`endif

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right-free (LSB-first) square-and-multiply controller driving an
// external precompute engine and a shared Montgomery multiplier.
// m starts at 1 in the plain domain and t at y*2^WIDTH mod N, so each
// MUL m*t*2^-WIDTH keeps m in the plain domain and result = y^d mod N.
// Optional macro RSA_EXP_EARLY_EXIT_EN: stop after the multiply at the
// highest set exponent bit (d=0 skips straight from PREP to DONE).
// Without it every exponent bit is squared (constant-time schedule).
//
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   PREP  | precompute engine converting y into the Montgomery domain
//   MUL   | Montgomery call m*t for a set exponent bit
//   SQR   | Montgomery call t*t, then move to the next bit
//   DONE  | one-cycle finish pulse
module rsa_exp_ctrl import rsa_pkg::*; #(
  parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  rsa_exp_ctrl_if.slave bus
);

  rsa_state_e       state, state_nxt;
  logic [WIDTH-1:0] n_q, y_q, m_q, t_q;
  logic             prep_start_q, mont_start_q;
  logic             prep_go, mont_go;
  logic             load, advance;
  logic             bit0, next_bit, last;
`ifdef RSA_EXP_EARLY_EXIT_EN
  logic             at_top, d_zero;
`endif

  rsa_exp_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .d_in     (bus.d),
    .advance  (advance),
    .bit0     (bit0),
    .next_bit (next_bit),
    .last     (last)
`ifdef RSA_EXP_EARLY_EXIT_EN
    ,
    .at_top   (at_top),
    .d_zero   (d_zero)
`endif
  );

  // State register and registered one-cycle engine start pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      prep_start_q <= 1'b0;
      mont_start_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      prep_start_q <= prep_go;
      mont_start_q <= mont_go;
    end
  end

  // Next state; engine finishes are only honoured in the state awaiting them.
  always_comb begin
    state_nxt = state;
    prep_go   = 1'b0;
    mont_go   = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          prep_go   = 1'b1;
          state_nxt = PREP;
        end
      end
      PREP: begin
        if (bus.prep_finish) begin
          mont_go   = 1'b1;
          state_nxt = bit0 ? MUL : SQR;
`ifdef RSA_EXP_EARLY_EXIT_EN
          if (d_zero) begin
            mont_go   = 1'b0;
            state_nxt = DONE;
          end
`endif
        end
      end
      MUL: begin
        if (bus.mont_finish) begin
          mont_go   = 1'b1;
          state_nxt = SQR;
`ifdef RSA_EXP_EARLY_EXIT_EN
          if (at_top) begin
            mont_go   = 1'b0;
            state_nxt = DONE;
          end
`endif
        end
      end
      SQR: begin
        if (bus.mont_finish) begin
          advance = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end else begin
            mont_go   = 1'b1;
            state_nxt = next_bit ? MUL : SQR;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and the running multiply (m) and square (t) values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q <= '0;
      y_q <= '0;
      m_q <= '0;
      t_q <= '0;
    end else begin
      if (load) begin
        n_q <= bus.N;
        y_q <= bus.y;
        m_q <= WIDTH'(1);
      end
      if (state == PREP && bus.prep_finish) t_q <= bus.prep_m;
      if (state == MUL  && bus.mont_finish) m_q <= bus.mont_m;
      if (state == SQR  && bus.mont_finish) t_q <= bus.mont_m;
    end
  end

  // m and t only change on the edge that consumes a finish, so operands
  // stay put for the whole call.
  assign bus.result     = m_q;
  assign bus.finish     = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.prep_start = prep_start_q;
  assign bus.prep_a     = y_q;
  assign bus.prep_N     = n_q;
  assign bus.mont_start = mont_start_q;
  assign bus.mont_a     = (state == MUL) ? m_q : t_q;
  assign bus.mont_b     = t_q;
  assign bus.mont_N     = n_q;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl at WIDTH=8 and WIDTH=256 with behavioural
// precompute / Montgomery engines of random latency.
module tb_rsa_exp_ctrl;
  import rsa_pkg::*;

  typedef logic [519:0] wide_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   calls [2];
  int   preps [2];
  int   latsum [2];
  int   viol [2];
  int   force_lat = 0;

  always #5 clk = ~clk;

  rsa_exp_ctrl_if #(.WIDTH(8))   b8 ();
  rsa_exp_ctrl_if #(.WIDTH(256)) b256 ();

  rsa_exp_ctrl #(.WIDTH(8))   dut8   (.clk(clk), .rst_n(rst_n), .bus(b8));
  rsa_exp_ctrl #(.WIDTH(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(b256));

  function automatic wide_t mont_fn(input wide_t a, input wide_t b, input wide_t n, input int w);
    wide_t x;
    x = a * b;
    for (int k = 0; k < w; k++) begin
      if (x[0]) x = x + n;
      x = x >> 1;
    end
    return x % n;
  endfunction

  function automatic wide_t prep_fn(input wide_t y, input wide_t n, input int w);
    return (y << w) % n;
  endfunction

  function automatic wide_t modexp_fn(input wide_t y, input wide_t d, input wide_t n, input int w);
    wide_t r, b;
    r = 1;
    b = y % n;
    for (int k = 0; k < w; k++) begin
      if (d[k]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic int exp_calls(input wide_t d, input int w);
    int pop;
    pop = 0;
    for (int k = 0; k < w; k++) if (d[k]) pop++;
`ifdef RSA_EXP_EARLY_EXIT_EN
    begin
      int top;
      top = 0;
      for (int k = 0; k < w; k++) if (d[k]) top = k;
      return (pop == 0) ? 0 : top + pop;
    end
`else
    return w + pop;
`endif
  endfunction

  function automatic wide_t res_of(input int ix);
    return (ix == 0) ? wide_t'(b8.result) : wide_t'(b256.result);
  endfunction

  function automatic logic fin_of(input int ix);
    return (ix == 0) ? b8.finish : b256.finish;
  endfunction

  function automatic logic busy_of(input int ix);
    return (ix == 0) ? b8.busy : b256.busy;
  endfunction

  task automatic check(input string tag, input wide_t obs, input wide_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ix, input logic st, input wide_t y, input wide_t d, input wide_t n);
    if (ix == 0) begin
      b8.y = y[7:0]; b8.d = d[7:0]; b8.N = n[7:0]; b8.start = st;
    end else begin
      b256.y = y[255:0]; b256.d = d[255:0]; b256.N = n[255:0]; b256.start = st;
    end
  endtask

  // One exponentiation; restart_at > 0 pulses a bogus start while busy.
  task automatic run_op(input int ix, input wide_t y, input wide_t d, input wide_t n,
                        input wide_t exp_r, input int restart_at, input string tag);
    int    w, cyc, extra_fin, res_chg, busy_tail;
    w = (ix == 0) ? 8 : 256;
    calls[ix] = 0; preps[ix] = 0; latsum[ix] = 0; viol[ix] = 0;
    drive(ix, 1'b1, y, d, n);
    @(posedge clk); #1;
    drive(ix, 1'b0, y, d, n);
    check({tag, " busy after start"}, wide_t'(busy_of(ix)), wide_t'(1));
    cyc = 1;
    while (fin_of(ix) !== 1'b1 && cyc < 20000) begin
      if (restart_at > 0 && cyc >= restart_at) drive(ix, cyc == restart_at, 5, 6, 7);
      @(posedge clk); #1;
      cyc++;
    end
    drive(ix, 1'b0, y, d, n);
    check({tag, " finish seen"}, wide_t'(fin_of(ix)), wide_t'(1));
    check({tag, " result"}, res_of(ix), exp_r);
    check({tag, " mont calls"}, wide_t'(calls[ix]), wide_t'(exp_calls(d, w)));
    check({tag, " prep calls"}, wide_t'(preps[ix]), wide_t'(1));
    check({tag, " latency"}, wide_t'(cyc), wide_t'(2 + latsum[ix] + exp_calls(d, w)));
    check({tag, " engine protocol"}, wide_t'(viol[ix]), wide_t'(0));
    extra_fin = 0; res_chg = 0; busy_tail = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (fin_of(ix) !== 1'b0) extra_fin++;
      if (busy_of(ix) !== 1'b0) busy_tail++;
      if (res_of(ix) !== exp_r) res_chg++;
    end
    check({tag, " extra finish"}, wide_t'(extra_fin), wide_t'(0));
    check({tag, " busy after done"}, wide_t'(busy_tail), wide_t'(0));
    check({tag, " result held"}, wide_t'(res_chg), wide_t'(0));
  endtask

  // Behavioural engines for the WIDTH=8 instance.
  initial begin : eng8
    wide_t a, b, n, r;
    int    lat;
    logic  is_prep;
    b8.prep_finish = 1'b0; b8.mont_finish = 1'b0; b8.prep_m = '0; b8.mont_m = '0;
    @(posedge clk); #1;
    forever begin
      if (b8.prep_start === 1'b1 || b8.mont_start === 1'b1) begin
        is_prep = (b8.prep_start === 1'b1);
        a = is_prep ? wide_t'(b8.prep_a) : wide_t'(b8.mont_a);
        b = wide_t'(b8.mont_b);
        n = is_prep ? wide_t'(b8.prep_N) : wide_t'(b8.mont_N);
        if (is_prep) preps[0]++; else calls[0]++;
        lat = (force_lat > 0) ? force_lat : int'($urandom_range(4, 1));
        latsum[0] += lat;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
          if (b8.busy === 1'b1) begin
            if (b8.prep_start !== 1'b0 || b8.mont_start !== 1'b0) viol[0]++;
            if (is_prep && (wide_t'(b8.prep_a) !== a || wide_t'(b8.prep_N) !== n)) viol[0]++;
            if (!is_prep && (wide_t'(b8.mont_a) !== a || wide_t'(b8.mont_b) !== b ||
                             wide_t'(b8.mont_N) !== n)) viol[0]++;
          end
        end
        r = is_prep ? prep_fn(a, n, 8) : mont_fn(a, b, n, 8);
        if (is_prep) begin b8.prep_m = r[7:0]; b8.prep_finish = 1'b1; end
        else begin b8.mont_m = r[7:0]; b8.mont_finish = 1'b1; end
        @(posedge clk); #1;
        b8.prep_finish = 1'b0; b8.mont_finish = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // Behavioural engines for the WIDTH=256 instance.
  initial begin : eng256
    wide_t a, b, n, r;
    int    lat;
    logic  is_prep;
    b256.prep_finish = 1'b0; b256.mont_finish = 1'b0; b256.prep_m = '0; b256.mont_m = '0;
    @(posedge clk); #1;
    forever begin
      if (b256.prep_start === 1'b1 || b256.mont_start === 1'b1) begin
        is_prep = (b256.prep_start === 1'b1);
        a = is_prep ? wide_t'(b256.prep_a) : wide_t'(b256.mont_a);
        b = wide_t'(b256.mont_b);
        n = is_prep ? wide_t'(b256.prep_N) : wide_t'(b256.mont_N);
        if (is_prep) preps[1]++; else calls[1]++;
        lat = (force_lat > 0) ? force_lat : int'($urandom_range(4, 1));
        latsum[1] += lat;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
          if (b256.busy === 1'b1) begin
            if (b256.prep_start !== 1'b0 || b256.mont_start !== 1'b0) viol[1]++;
            if (is_prep && (wide_t'(b256.prep_a) !== a || wide_t'(b256.prep_N) !== n)) viol[1]++;
            if (!is_prep && (wide_t'(b256.mont_a) !== a || wide_t'(b256.mont_b) !== b ||
                             wide_t'(b256.mont_N) !== n)) viol[1]++;
          end
        end
        r = is_prep ? prep_fn(a, n, 256) : mont_fn(a, b, n, 256);
        if (is_prep) begin b256.prep_m = r[255:0]; b256.prep_finish = 1'b1; end
        else begin b256.mont_m = r[255:0]; b256.mont_finish = 1'b1; end
        @(posedge clk); #1;
        b256.prep_finish = 1'b0; b256.mont_finish = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
    $fatal(1, "time limit");
  end

  initial begin : main
    wide_t ry, rd, rn;
    int    k;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst result8",     wide_t'(b8.result),       wide_t'(0));
    check("rst finish8",     wide_t'(b8.finish),       wide_t'(0));
    check("rst busy8",       wide_t'(b8.busy),         wide_t'(0));
    check("rst prep_start8", wide_t'(b8.prep_start),   wide_t'(0));
    check("rst mont_start8", wide_t'(b8.mont_start),   wide_t'(0));
    check("rst busy256",     wide_t'(b256.busy),       wide_t'(0));
    check("rst result256",   wide_t'(b256.result),     wide_t'(0));

    run_op(0, 3, 11, 13, 9, 0, "y3_d11");
    run_op(0, 7, 0, 13, 1, 0, "d0");
    run_op(0, 3, 11, 13, 9, 3, "start_while_busy");

    // Reset while a square is outstanding; its finish lands in IDLE.
    force_lat = 3;
    drive(0, 1'b1, 5, 10, 13);
    @(posedge clk); #1;
    drive(0, 1'b0, 5, 10, 13);
    k = 0;
    while (b8.mont_start !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    check("abort first call is square", wide_t'(b8.mont_start), wide_t'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort busy",   wide_t'(b8.busy),   wide_t'(0));
    check("abort result", wide_t'(b8.result), wide_t'(0));
    k = 0;
    while (b8.mont_finish !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    check("stale finish arrived", wide_t'(b8.mont_finish), wide_t'(1));
    @(posedge clk); #1;
    check("stale finish busy",       wide_t'(b8.busy),       wide_t'(0));
    check("stale finish mont_start", wide_t'(b8.mont_start), wide_t'(0));
    check("stale finish result",     wide_t'(b8.result),     wide_t'(0));
    force_lat = 0;
    repeat (3) @(posedge clk);
    #1;
    run_op(0, 2, 10, 221, 140, 0, "after_abort");

    for (int j = 0; j < 6; j++) begin
      ry = wide_t'($urandom_range(255, 0));
      rd = (j == 0) ? wide_t'(255) : (j == 1) ? wide_t'(128) : wide_t'($urandom_range(255, 0));
      rn = wide_t'(2 * $urandom_range(127, 1) + 1);
      run_op(0, ry, rd, rn, modexp_fn(ry, rd, rn, 8), 0, "rand8");
    end

    run_op(1, 279, 398, 221, modexp_fn(279, 398, 221, 256), 0, "w256_fixed");
    ry = '0; rd = '0; rn = '0;
    for (int j = 0; j < 8; j++) begin
      ry[j*32 +: 32] = $urandom();
      rd[j*32 +: 32] = $urandom();
      rn[j*32 +: 32] = $urandom();
    end
    rn[0] = 1'b1;
    rn[255] = 1'b1;
    run_op(1, ry, rd, rn, modexp_fn(ry, rd, rn, 256), 0, "w256_rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
